// File: rtl/ioctl_pkg.sv
// ioctl_pkg: shared definitions for the HPS ioctl upload and download paths
package ioctl_pkg;
  typedef enum logic [1:0] {IDLE, PAUSE, READY, READ} state_e;
  localparam logic [7:0] FILL = 8'hFF;
  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_CORE = 8'd1;
  localparam logic [7:0] IDX_NVRAM = 8'd4;
endpackage

// File: rtl/ioctl_upload_reader.sv
// ioctl_upload_reader: serves ioctl upload reads from a game RAM while holding the core paused
module ioctl_upload_reader
  import ioctl_pkg::*;
#(
  parameter logic [7:0] INDEX = IDX_NVRAM,
  parameter int ADDR_W = 10,
  parameter int SIZE = 1024,
  parameter int RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              pause_req,
  input  logic              pause_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_data,
  output logic              active
);
  state_e state_q, state_d;
  logic [24:0] addr_q, addr_d;
  logic pend_q, pend_d, oor_q, oor_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] din_q, din_d;
  logic wait_q, wait_d, preq_q, preq_d, rd_q, rd_d, act_q, act_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic sel, fresh, issue, inr;
  logic [24:0] src;
  assign sel = ioctl_upload && ioctl_index == INDEX;
  assign fresh = ioctl_rd && !wait_q;
  assign src = pend_q ? addr_q : ioctl_addr;
  assign inr = src < 25'(SIZE);
  // next state: requests queued during the pause are issued on the edge that sees the ack
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    pend_d = pend_q;
    oor_d = oor_q;
    cnt_d = cnt_q;
    din_d = din_q;
    wait_d = wait_q;
    preq_d = preq_q;
    raddr_d = raddr_q;
    rd_d = 1'b0;
    issue = 1'b0;
    unique case (state_q)
      IDLE: begin
        preq_d = sel;
        state_d = sel ? PAUSE : IDLE;
      end
      PAUSE: begin
        if (!sel) begin
          preq_d = 1'b0;
          pend_d = 1'b0;
          wait_d = 1'b0;
          state_d = IDLE;
        end else if (pause_ack) begin
          issue = pend_q || fresh;
          state_d = READY;
        end else if (fresh) begin
          addr_d = ioctl_addr;
          pend_d = 1'b1;
          wait_d = 1'b1;
        end
      end
      READY: begin
        preq_d = sel;
        state_d = sel ? READY : IDLE;
        issue = sel && fresh;
      end
      READ: begin
        if (cnt_q == 3'd0) begin
          din_d = oor_q ? FILL : ram_data;
          wait_d = 1'b0;
          preq_d = sel;
          state_d = sel ? READY : IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      raddr_d = inr ? src[ADDR_W-1:0] : raddr_q;
      rd_d = inr;
      oor_d = !inr;
      cnt_d = inr ? 3'(RAM_LATENCY) : 3'd0;
      wait_d = 1'b1;
      pend_d = 1'b0;
      state_d = READ;
    end
    act_d = state_d != IDLE;
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      pend_q <= 1'b0;
      oor_q <= 1'b0;
      cnt_q <= '0;
      din_q <= 8'h00;
      wait_q <= 1'b0;
      preq_q <= 1'b0;
      raddr_q <= '0;
      rd_q <= 1'b0;
      act_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      pend_q <= pend_d;
      oor_q <= oor_d;
      cnt_q <= cnt_d;
      din_q <= din_d;
      wait_q <= wait_d;
      preq_q <= preq_d;
      raddr_q <= raddr_d;
      rd_q <= rd_d;
      act_q <= act_d;
    end
  end
  assign ioctl_din = din_q;
  assign ioctl_wait = wait_q;
  assign pause_req = preq_q;
  assign ram_addr = raddr_q;
  assign ram_rd = rd_q;
  assign active = act_q;
endmodule
